// File: rtl/pkt_slot_buffer.sv
// Slot-based packet buffer: whole packets land in fixed-size SRAM slots, are optionally
// handed to a processor for in-place edits, then drained in arrival order.
module pkt_slot_buffer #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned CTRL_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned SLOT_AWIDTH = 8,
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned PROC_MODE   = 1,
    localparam int unsigned SW = $clog2(NUM_SLOTS),
    localparam int unsigned AW = SLOT_AWIDTH,
    localparam int unsigned WW = CTRL_WIDTH + DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  proc_valid,
    output logic [SW-1:0]         proc_slot,
    output logic [AW:0]           proc_len,
    input  logic [AW-1:0]         proc_addr,
    input  logic [WW-1:0]         proc_wdata,
    input  logic                  proc_we,
    input  logic                  proc_re,
    output logic [WW-1:0]         proc_rdata,
    input  logic                  proc_done,
    output logic [31:0]           pkt_in_cnt,
    output logic [31:0]           pkt_out_cnt,
    output logic [31:0]           trunc_cnt
);

    typedef enum logic [1:0] {
        SLOT_FREE  = 2'd0,
        SLOT_FILL  = 2'd1,
        SLOT_PROC  = 2'd2,
        SLOT_READY = 2'd3
    } slot_state_e;

    localparam logic [AW:0] SLOT_WORDS   = {1'b1, {AW{1'b0}}};
    localparam slot_state_e FILLED_STATE = (PROC_MODE != 0) ? SLOT_PROC : SLOT_READY;

    slot_state_e      state_q [NUM_SLOTS];
    slot_state_e      state_d [NUM_SLOTS];
    logic [AW:0]      len_q   [NUM_SLOTS];
    logic [AW:0]      len_d   [NUM_SLOTS];
    logic [SW-1:0]    wr_slot_q, wr_slot_d, proc_slot_q, proc_slot_d, rd_slot_q, rd_slot_d;
    logic [AW:0]      wr_cnt_q, wr_cnt_d, rd_off_q, rd_off_d;
    logic             seen_data_q, seen_data_d, trunc_q, trunc_d, out_wr_q, out_wr_d;
    logic [31:0]      pkt_in_cnt_q, pkt_in_cnt_d, pkt_out_cnt_q, pkt_out_cnt_d;
    logic [31:0]      trunc_cnt_q, trunc_cnt_d;

    logic [WW-1:0]    mem [NUM_SLOTS * (2 ** AW)];
    logic [WW-1:0]    rdata_q;

    logic             accept, eop, proc_acc, drain, drain_last, b_rd;
    logic [AW-1:0]    wr_addr;
    logic [SW+AW-1:0] b_addr;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        wr_slot_d     = wr_slot_q;
        proc_slot_d   = proc_slot_q;
        rd_slot_d     = rd_slot_q;
        wr_cnt_d      = wr_cnt_q;
        rd_off_d      = rd_off_q;
        seen_data_d   = seen_data_q;
        trunc_d       = trunc_q;
        pkt_in_cnt_d  = pkt_in_cnt_q;
        pkt_out_cnt_d = pkt_out_cnt_q;
        trunc_cnt_d   = trunc_cnt_q;

        in_rdy  = (state_q[wr_slot_q] == SLOT_FREE) || (state_q[wr_slot_q] == SLOT_FILL);
        accept  = in_wr && in_rdy;
        eop     = accept && (in_ctrl != '0) && seen_data_q;
        // Once the slot is full, every further word lands on the last location.
        wr_addr = wr_cnt_q[AW] ? '1 : wr_cnt_q[AW-1:0];

        proc_valid = (state_q[proc_slot_q] == SLOT_PROC);
        proc_acc   = proc_valid && (proc_we || proc_re);
        drain      = !proc_acc && out_rdy && (state_q[rd_slot_q] == SLOT_READY);
        drain_last = drain && ((rd_off_q + 1'b1) == len_q[rd_slot_q]);
        b_rd       = drain || (proc_valid && proc_re);
        b_addr     = proc_acc ? {proc_slot_q, proc_addr} : {rd_slot_q, rd_off_q[AW-1:0]};
        out_wr_d   = drain;

        if (eop) begin
            state_d[wr_slot_q] = FILLED_STATE;
            len_d[wr_slot_q]   = wr_cnt_q[AW] ? wr_cnt_q : wr_cnt_q + 1'b1;
            if (trunc_q || wr_cnt_q[AW]) trunc_cnt_d = trunc_cnt_q + 32'd1;
            pkt_in_cnt_d = pkt_in_cnt_q + 32'd1;
            wr_slot_d    = wr_slot_q + 1'b1;
            wr_cnt_d     = '0;
            seen_data_d  = 1'b0;
            trunc_d      = 1'b0;
        end else if (accept) begin
            state_d[wr_slot_q] = SLOT_FILL;
            if (in_ctrl == '0) seen_data_d = 1'b1;
            if (wr_cnt_q[AW]) trunc_d = 1'b1;
            else              wr_cnt_d = wr_cnt_q + 1'b1;
        end

        if (proc_valid && proc_done) begin
            state_d[proc_slot_q] = SLOT_READY;
            proc_slot_d          = proc_slot_q + 1'b1;
        end

        if (drain_last) begin
            state_d[rd_slot_q] = SLOT_FREE;
            rd_slot_d          = rd_slot_q + 1'b1;
            rd_off_d           = '0;
            pkt_out_cnt_d      = pkt_out_cnt_q + 32'd1;
        end else if (drain) begin
            rd_off_d = rd_off_q + 1'b1;
        end

        if (flush) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                state_d[i] = SLOT_FREE;
                len_d[i]   = '0;
            end
            wr_slot_d     = '0;
            proc_slot_d   = '0;
            rd_slot_d     = '0;
            wr_cnt_d      = '0;
            rd_off_d      = '0;
            seen_data_d   = 1'b0;
            trunc_d       = 1'b0;
            out_wr_d      = 1'b0;
            pkt_in_cnt_d  = '0;
            pkt_out_cnt_d = '0;
            trunc_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= SLOT_FREE;
                len_q[i]   <= '0;
            end
            wr_slot_q     <= '0;
            proc_slot_q   <= '0;
            rd_slot_q     <= '0;
            wr_cnt_q      <= '0;
            rd_off_q      <= '0;
            seen_data_q   <= 1'b0;
            trunc_q       <= 1'b0;
            out_wr_q      <= 1'b0;
            pkt_in_cnt_q  <= '0;
            pkt_out_cnt_q <= '0;
            trunc_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            wr_slot_q     <= wr_slot_d;
            proc_slot_q   <= proc_slot_d;
            rd_slot_q     <= rd_slot_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_off_q      <= rd_off_d;
            seen_data_q   <= seen_data_d;
            trunc_q       <= trunc_d;
            out_wr_q      <= out_wr_d;
            pkt_in_cnt_q  <= pkt_in_cnt_d;
            pkt_out_cnt_q <= pkt_out_cnt_d;
            trunc_cnt_q   <= trunc_cnt_d;
        end
    end

    // Port B read register; cleared so an in-flight read never surfaces after reset/flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      rdata_q <= '0;
        else if (flush) rdata_q <= '0;
        else if (b_rd)  rdata_q <= mem[b_addr];
    end

    always_ff @(posedge clk) begin
        if (accept) mem[{wr_slot_q, wr_addr}] <= {in_ctrl, in_data};
        if (proc_valid && proc_we) mem[{proc_slot_q, proc_addr}] <= proc_wdata;
    end

    assign proc_slot   = proc_slot_q;
    assign proc_len    = len_q[proc_slot_q];
    assign proc_rdata  = rdata_q;
    assign out_wr      = out_wr_q;
    assign out_data    = rdata_q[DATA_WIDTH-1:0];
    assign out_ctrl    = rdata_q[WW-1:DATA_WIDTH];
    assign pkt_in_cnt  = pkt_in_cnt_q;
    assign pkt_out_cnt = pkt_out_cnt_q;
    assign trunc_cnt   = trunc_cnt_q;

endmodule

// File: tb/tb_pkt_slot_buffer.sv
// Scoreboard bench: DUT A (processor mode, 8-word slots) and DUT B (bypass mode).
module tb_pkt_slot_buffer;
    localparam int unsigned DW = 64, CW = 8, AW = 3, NS = 4, SW = 2, WW = 72;

    logic clk = 1'b0, reset = 1'b1, a_flush = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] a_in_data = '0, b_in_data = '0, a_out_data, b_out_data;
    logic [CW-1:0] a_in_ctrl = '0, b_in_ctrl = '0, a_out_ctrl, b_out_ctrl;
    logic          a_in_wr = 1'b0, b_in_wr = 1'b0, a_in_rdy, b_in_rdy, a_out_wr, b_out_wr;
    logic          a_out_rdy = 1'b1, b_out_rdy = 1'b1;
    logic          a_proc_valid, b_proc_valid;
    logic [SW-1:0] a_proc_slot, b_proc_slot;
    logic [AW:0]   a_proc_len, b_proc_len;
    logic [AW-1:0] a_proc_addr = '0;
    logic [WW-1:0] a_proc_wdata = '0, a_proc_rdata, b_proc_rdata;
    logic          a_proc_we = 1'b0, a_proc_re = 1'b0, a_proc_done = 1'b0;
    logic [31:0]   a_pkt_in_cnt, a_pkt_out_cnt, a_trunc_cnt, b_pkt_in_cnt, b_pkt_out_cnt, b_trunc_cnt;

    pkt_slot_buffer #(.DATA_WIDTH(DW), .SLOT_AWIDTH(AW), .NUM_SLOTS(NS), .PROC_MODE(1)) u_dut_a (
        .clk(clk), .reset(reset), .flush(a_flush),
        .in_data(a_in_data), .in_ctrl(a_in_ctrl), .in_wr(a_in_wr), .in_rdy(a_in_rdy),
        .out_data(a_out_data), .out_ctrl(a_out_ctrl), .out_wr(a_out_wr), .out_rdy(a_out_rdy),
        .proc_valid(a_proc_valid), .proc_slot(a_proc_slot), .proc_len(a_proc_len),
        .proc_addr(a_proc_addr), .proc_wdata(a_proc_wdata), .proc_we(a_proc_we),
        .proc_re(a_proc_re), .proc_rdata(a_proc_rdata), .proc_done(a_proc_done),
        .pkt_in_cnt(a_pkt_in_cnt), .pkt_out_cnt(a_pkt_out_cnt), .trunc_cnt(a_trunc_cnt)
    );

    pkt_slot_buffer #(.DATA_WIDTH(DW), .SLOT_AWIDTH(AW), .NUM_SLOTS(NS), .PROC_MODE(0)) u_dut_b (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_data(b_in_data), .in_ctrl(b_in_ctrl), .in_wr(b_in_wr), .in_rdy(b_in_rdy),
        .out_data(b_out_data), .out_ctrl(b_out_ctrl), .out_wr(b_out_wr), .out_rdy(b_out_rdy),
        .proc_valid(b_proc_valid), .proc_slot(b_proc_slot), .proc_len(b_proc_len),
        .proc_addr('0), .proc_wdata('0), .proc_we(1'b0),
        .proc_re(1'b0), .proc_rdata(b_proc_rdata), .proc_done(1'b0),
        .pkt_in_cnt(b_pkt_in_cnt), .pkt_out_cnt(b_pkt_out_cnt), .trunc_cnt(b_trunc_cnt)
    );

    int unsigned   checks = 0, errors = 0;
    logic [WW-1:0] exp_a[$], exp_b[$];
    logic [WW-1:0] img [8];
    int unsigned   img_len = 0;
    logic          b_toggle = 1'b0, b_rdy_prev = 1'b1, b_pv_seen = 1'b0;
    int unsigned   b_late = 0;

    function automatic void chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitors: pop the expected word whenever a DUT presents output.
    always @(negedge clk) begin
        if (a_out_wr) begin
            if (exp_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL out_a_unexpected: got %h expected no word", {a_out_ctrl, a_out_data});
            end else chk("out_a_word", {a_out_ctrl, a_out_data}, exp_a.pop_front());
        end
    end

    always @(posedge clk) b_rdy_prev <= b_out_rdy;
    always @(posedge clk) if (b_toggle) begin #1; b_out_rdy = ~b_out_rdy; end

    always @(negedge clk) begin
        if (b_proc_valid) b_pv_seen = 1'b1;
        if (b_out_wr && !b_rdy_prev) b_late++;
        if (b_out_wr) begin
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL out_b_unexpected: got %h expected no word", {b_out_ctrl, b_out_data});
            end else chk("out_b_word", {b_out_ctrl, b_out_data}, exp_b.pop_front());
        end
    end

    task automatic send_word(input bit sel, input logic [CW-1:0] c, input logic [DW-1:0] d);
        int unsigned n = 0;
        while (!(sel ? b_in_rdy : a_in_rdy) && n < 1000) begin @(posedge clk); #1; n++; end
        chk("in_rdy_wait", sel ? b_in_rdy : a_in_rdy, 1);
        if (sel) begin b_in_ctrl = c; b_in_data = d; b_in_wr = 1'b1; end
        else     begin a_in_ctrl = c; a_in_data = d; a_in_wr = 1'b1; end
        @(posedge clk); #1;
        a_in_wr = 1'b0; b_in_wr = 1'b0;
    endtask

    // Packet k of n words: 2 headers, data, EOP; stored image keeps only the last word past 8.
    task automatic send_pkt(input bit sel, input logic [31:0] k, input int unsigned n);
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        img_len = (n < 8) ? n : 8;
        for (int unsigned i = 0; i < n; i++) begin
            c = (i < 2) ? 8'hFF : ((i == n - 1) ? 8'h01 : 8'h00);
            d = {k, i};
            img[(i < 8) ? i : 7] = {c, d};
            send_word(sel, c, d);
        end
    endtask

    task automatic push_img(input bit sel);
        for (int unsigned i = 0; i < img_len; i++)
            if (sel) exp_b.push_back(img[i]); else exp_a.push_back(img[i]);
    endtask

    task automatic pulse_done();
        a_proc_done = 1'b1;
        @(posedge clk); #1;
        a_proc_done = 1'b0;
    endtask

    task automatic wait_pv();
        int unsigned n = 0;
        while (!a_proc_valid && n < 1000) begin @(posedge clk); #1; n++; end
        chk("proc_valid_wait", a_proc_valid, 1);
    endtask

    task automatic wait_out_wr();
        int unsigned n = 0;
        while (!a_out_wr && n < 200) begin @(posedge clk); #1; n++; end
        chk("out_wr_wait", a_out_wr, 1);
    endtask

    task automatic wait_out(input bit sel, input logic [31:0] target);
        int unsigned n = 0;
        while ((sel ? b_pkt_out_cnt : a_pkt_out_cnt) != target && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk(sel ? "b_pkt_out_cnt" : "a_pkt_out_cnt", sel ? b_pkt_out_cnt : a_pkt_out_cnt, target);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_out_wr"}, a_out_wr, 0);
        chk({tag, "_in_rdy"}, a_in_rdy, 1);
        chk({tag, "_pkt_in"}, a_pkt_in_cnt, 0);
        chk({tag, "_pkt_out"}, a_pkt_out_cnt, 0);
        chk({tag, "_trunc"}, a_trunc_cnt, 0);
        chk({tag, "_proc_valid"}, a_proc_valid, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_cleared("reset");
        chk("reset_proc_len", a_proc_len, 0);

        // One 8-word packet, processor rewrite of word 3, then drain.
        send_pkt(0, 1, 8);
        chk("p1_proc_valid", a_proc_valid, 1);
        chk("p1_proc_slot", a_proc_slot, 0);
        chk("p1_proc_len", a_proc_len, 8);
        chk("p1_pkt_in", a_pkt_in_cnt, 1);
        a_proc_addr = 3; a_proc_wdata = {8'h00, 64'hDEAD_BEEF}; a_proc_we = 1'b1;
        @(posedge clk); #1;
        a_proc_we = 1'b0; a_proc_re = 1'b1;
        @(posedge clk); #1;
        a_proc_re = 1'b0;
        chk("p1_rdata", a_proc_rdata, {8'h00, 64'hDEAD_BEEF});
        img[3] = {8'h00, 64'hDEAD_BEEF};
        push_img(0);
        pulse_done();
        @(negedge clk) chk("p1_out_wr_t1", a_out_wr, 0);
        @(negedge clk) chk("p1_out_wr_t2", a_out_wr, 1);
        @(posedge clk); #1;
        wait_out(0, 1);

        // Back-pressure: four packets fill every slot, the fifth waits for a drain.
        for (int unsigned k = 2; k <= 5; k++) begin
            send_pkt(0, k, 4);
            push_img(0);
        end
        chk("bp_in_rdy", a_in_rdy, 0);
        chk("bp_proc_slot", a_proc_slot, 1);
        fork
            begin send_pkt(0, 6, 4); push_img(0); end
            begin for (int unsigned j = 0; j < 5; j++) begin wait_pv(); pulse_done(); end end
        join
        wait_out(0, 6);
        chk("bp_pkt_in", a_pkt_in_cnt, 6);

        // Truncation: 12 words into an 8-word slot.
        send_pkt(0, 7, 12);
        chk("tr_proc_len", a_proc_len, 8);
        chk("tr_trunc_cnt", a_trunc_cnt, 1);
        push_img(0);
        pulse_done();
        wait_out(0, 7);

        // Asynchronous reset mid-drain.
        send_pkt(0, 8, 8);
        push_img(0);
        pulse_done();
        wait_out_wr();
        reset = 1'b1;
        exp_a.delete();
        #1;
        check_cleared("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        send_pkt(0, 9, 4);
        chk("rst_next_slot", a_proc_slot, 0);
        chk("rst_next_valid", a_proc_valid, 1);
        chk("rst_next_len", a_proc_len, 4);
        push_img(0);
        pulse_done();
        wait_out(0, 1);

        // Synchronous flush mid-drain.
        send_pkt(0, 10, 8);
        push_img(0);
        pulse_done();
        wait_out_wr();
        a_flush = 1'b1;
        @(posedge clk); #1;
        a_flush = 1'b0;
        exp_a.delete();
        check_cleared("flush");
        send_pkt(0, 11, 5);
        chk("fl_next_slot", a_proc_slot, 0);
        chk("fl_next_len", a_proc_len, 5);
        push_img(0);
        pulse_done();
        wait_out(0, 1);

        // Bypass DUT with out_rdy toggling every cycle.
        b_toggle = 1'b1;
        send_pkt(1, 20, 4); push_img(1);
        send_pkt(1, 21, 6); push_img(1);
        send_pkt(1, 22, 5); push_img(1);
        wait_out(1, 3);
        b_toggle = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("b_pkt_in", b_pkt_in_cnt, 3);
        chk("b_proc_valid_seen", b_pv_seen, 0);
        chk("b_write_after_rdy_low", b_late, 0);

        chk("exp_a_empty", exp_a.size(), 0);
        chk("exp_b_empty", exp_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pkt_slot_buffer.md
# pkt_slot_buffer

Parametrised packet buffer for the user data path. It stores whole packets in `NUM_SLOTS` fixed-size slots of a shared SRAM and hands each complete packet to the embedded processor for in-place inspection and rewrite. After the processor releases a packet, the block streams it out in arrival order. It generalises the single-FIFO/processor-memory arrangement with configurable width, depth and slot count, per-packet ownership hand-off, a bypass mode, truncation handling and a software flush.

## Interface
Parameters:
- `DATA_WIDTH`, 64: data word width.
- `CTRL_WIDTH`, `DATA_WIDTH/8`: control word width.
- `SLOT_AWIDTH`, 8: words per slot = 2^`SLOT_AWIDTH`.
- `NUM_SLOTS`, 4: number of slots; power of two, ≥2.
- `PROC_MODE`, 1: 1 = processor owns each packet before output; 0 = bypass (pure packet FIFO).

Ports (`SW` = `log2(NUM_SLOTS)`, `AW` = `SLOT_AWIDTH`):
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `flush` in 1: synchronous; same effect as `reset` on the state (software-register driven).
- `in_data` in `DATA_WIDTH`: input data word.
- `in_ctrl` in `CTRL_WIDTH`: input control word.
- `in_wr` in 1: input word valid.
- `in_rdy` out 1: block can accept a word this cycle.
- `out_data` out `DATA_WIDTH`: output data word.
- `out_ctrl` out `CTRL_WIDTH`: output control word.
- `out_wr` out 1: output word valid.
- `out_rdy` in 1: downstream can accept a word.
- `proc_valid` out 1: a slot is owned by the processor.
- `proc_slot` out `SW`: index of the processor-owned slot.
- `proc_len` out `AW+1`: word count of that packet.
- `proc_addr` in `AW`: word offset within the processor slot.
- `proc_wdata` in `CTRL_WIDTH+DATA_WIDTH`: write word, `{ctrl,data}`.
- `proc_we` in 1: write strobe.
- `proc_re` in 1: read strobe.
- `proc_rdata` out `CTRL_WIDTH+DATA_WIDTH`: read word, valid one cycle after `proc_re`.
- `proc_done` in 1: one-cycle pulse; releases the processor slot.
- `pkt_in_cnt`, `pkt_out_cnt`, `trunc_cnt` out 32: status counters, wrapping.

## Operation
- SRAM holds `NUM_SLOTS*2^AW` words of `CTRL_WIDTH+DATA_WIDTH`, dual-port.
  - Port A: input writes only.
  - Port B: processor read/write, or output drain.
- Each slot has a 2-bit state: FREE → FILL → PROC → READY → FREE. With `PROC_MODE`=0, FILL goes directly to READY.
- Three round-robin pointers, each advancing by 1 mod `NUM_SLOTS`:
  - `wr_slot`: the slot being filled.
  - `proc_slot`: the slot the processor owns.
  - `rd_slot`: the slot being drained.
  - Packet order is preserved end to end.
- Filling:
  - `in_rdy` = state[`wr_slot`] ∈ {FREE, FILL}.
  - A word is accepted when `in_wr` && `in_rdy`. The first word moves the slot FREE→FILL.
  - End of packet is the first word with `in_ctrl`≠0 that follows a word with `in_ctrl`==0. Header words have `in_ctrl`≠0 and come before any data.
  - `in_wr` while `in_rdy`=0 is a protocol violation; those words are ignored.
- Truncation:
  - When the write offset reaches 2^AW−1, further words overwrite that last location, so the end-of-packet word is always retained.
  - Stored length saturates at 2^AW.
  - `trunc_cnt` increments once per truncated packet.
- Processor:
  - `proc_valid` = state[`proc_slot`]==PROC.
  - `proc_we`/`proc_re` are ignored while `proc_valid`=0.
  - `proc_done` with `proc_valid`=1: the slot goes to READY and `proc_slot` advances.
- Drain:
  - While state[`rd_slot`]==READY, `out_rdy`=1 and port B is not used by the processor, issue one read per cycle from offset 0 up to length−1.
  - Processor access has priority on port B; a drain cycle with a processor access is skipped.
  - After the last read the slot goes to FREE, `rd_slot` advances, and `pkt_out_cnt` increments.
- `pkt_in_cnt` increments on each end-of-packet word accepted.
- `reset`/`flush`:
  - All slot states, pointers, lengths and counters go to 0.
  - All outputs go to 0 (`in_rdy` reads 1 after reset since slot 0 is FREE).
  - An in-flight read is discarded.
  - SRAM contents are not cleared.

## Timing
- Input word accepted at cycle t is written at t.
- End-of-packet accepted at t: slot is PROC (or READY) at t+1, and `proc_valid`/`proc_len` are valid at t+1.
- `proc_re` at t → `proc_rdata` at t+1.
- `proc_we` at t → written at t; a read of the same address at t+1 returns the new value.
- `proc_done` at t → READY at t+1; first drain read at t+1; first `out_wr` at t+2.
- Drain read issued at t → `out_wr`=1 with that word at t+1. There is exactly one cycle of slack after `out_rdy` falls.
- Last drain read at t → slot FREE at t+1; if it is `wr_slot`, `in_rdy` rises at t+1.
- Simultaneous events in different slots (end-of-packet, `proc_done`, drain end) all take effect independently in the same cycle.
- All-slots-busy: `in_rdy`=0 until a drain completes.

## Test plan
- Reset then one packet (`NUM_SLOTS`=4, `PROC_MODE`=1): 2 header words + 5 data words + 1 EOP word → `proc_valid`=1, `proc_slot`=0, `proc_len`=8 one cycle after EOP. `proc_done` → 8 identical `out_wr` words starting 2 cycles later; `pkt_in_cnt`=`pkt_out_cnt`=1.
- Processor rewrite: write `{8'h00,64'hDEAD_BEEF}` at offset 3, read back next cycle → same value. Output word 3 equals it; all other words are unchanged.
- Back-pressure: 5 packets with no `proc_done` → `in_rdy`=0 after packet 4 fills. `proc_done` with `out_rdy`=1 → `in_rdy` returns after drain; output order is 1..5.
- `SLOT_AWIDTH`=3, 12-word packet → `proc_len`=8, output word 7 is the original EOP word, `trunc_cnt`=1.
- `PROC_MODE`=0, `out_rdy` toggled every cycle → `proc_valid` stays 0, no word is lost or duplicated, and at most one word is written after each `out_rdy` deassertion.
- `reset` asserted mid-drain → `out_wr`=0 immediately, counters 0, `in_rdy`=1. The next packet is stored in slot 0. Repeat with `flush` and the same result.
